// File: rtl/mdu.sv
// mdu -- iterative multiply/divide unit with HI/LO registers for the EX stage.
//   MULT/MULTU/DIV/DIVU take WIDTH cycles (radix-2, one step per cycle);
//   MTHI/MTLO write HI/LO in one cycle.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start, ctl[2:0]    request (sampled only while idle) and opcode
//                      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   a, b               operands (a is also the MTHI/MTLO source)
//   busy               mul/div in progress
//   done               one-cycle pulse: hi/lo hold a new mul/div result
//   hi, lo             HI/LO registers
module mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [CW-1:0]      cnt_q;
  logic               is_div_q;   // op in flight is a divide
  logic               neg_q;      // negate product / quotient
  logic               rneg_q;     // negate remainder (sign of dividend)
  logic               dvz_q;      // divisor was zero
  logic [WIDTH-1:0]   a_orig_q;   // raw dividend, returned in HI on divide by zero
  logic [WIDTH-1:0]   opb_q;      // multiplicand (mul) or divisor (div), magnitude
  // mul: {partial product, remaining multiplier bits}
  // div: {remainder, dividend bits still to shift in / quotient bits shifted in}
  logic [2*WIDTH-1:0] acc_q, acc_d;

  // operand magnitudes for request capture
  logic               op_signed;
  logic [WIDTH-1:0]   a_abs, b_abs;
  assign op_signed = ~ctl[0];
  assign a_abs = (op_signed && a[WIDTH-1]) ? -a : a;
  assign b_abs = (op_signed && b[WIDTH-1]) ? -b : b;

  // one radix-2 step
  logic [WIDTH:0] mul_sum, div_trial, div_diff;
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_trial - {1'b0, opb_q};

  always_comb begin
    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    if (is_div_q) begin
      // restoring: keep the trial remainder when the subtract borrows
      if (div_diff[WIDTH]) acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else                 acc_d = {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
    end
  end

  // sign-corrected result from the final step
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;
  assign prod = neg_q ? -acc_d : acc_d;
  assign quo  = neg_q  ? -acc_d[WIDTH-1:0]       : acc_d[WIDTH-1:0];
  assign rem  = rneg_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];

  always_comb begin
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div_q) begin
      res_hi = dvz_q ? a_orig_q : rem;
      res_lo = dvz_q ? '1       : quo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dvz_q    <= 1'b0;
      a_orig_q <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if (!ctl[2]) begin
              is_div_q <= ctl[1];
              neg_q    <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              rneg_q   <= op_signed & a[WIDTH-1];
              dvz_q    <= (b == '0);
              a_orig_q <= a;
              opb_q    <= ctl[1] ? b_abs : a_abs;
              acc_q    <= {{WIDTH{1'b0}}, (ctl[1] ? a_abs : b_abs)};
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= RUN;
            end else if (ctl[1:0] == 2'b00) begin
              hi_q <= a;
            end else if (ctl[1:0] == 2'b01) begin
              lo_q <= a;
            end
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_mdu.sv
module tb_mdu;
  logic        clk = 0;
  logic        reset;
  logic        start;
  logic [2:0]  ctl;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        start8;
  logic [2:0]  ctl8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mdu #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .start(start), .ctl(ctl), .a(a), .b(b),
                         .busy(busy), .done(done), .hi(hi), .lo(lo));
  mdu #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .start(start8), .ctl(ctl8), .a(a8), .b(b8),
                         .busy(busy8), .done(done8), .hi(hi8), .lo(lo8));

  // Issue one op on the 32-bit unit and wait (bounded) for done.
  task automatic do_op(input logic [2:0] c, input logic [31:0] aa, input logic [31:0] bb,
                       output logic [31:0] rh, output logic [31:0] rl,
                       output int bcyc, output bit got_done);
    @(negedge clk); start = 1; ctl = c; a = aa; b = bb;
    @(negedge clk); start = 0;
    bcyc = 0; got_done = 0;
    for (int i = 0; i < 100 && !got_done; i++) begin
      if (busy) bcyc++;
      if (done) got_done = 1;
      else @(negedge clk);
    end
    rh = hi; rl = lo;
  endtask

  task automatic test_reset;
    reset = 1; start = 0; ctl = 0; a = 0; b = 0;
    start8 = 0; ctl8 = 0; a8 = 0; b8 = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    n_chk++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {busy, done}); end
    n_chk++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
    n_chk++; if ({busy8, done8, hi8, lo8} !== 18'h0) begin n_fail++; $display("FAIL reset_w8: got %h want 0", {busy8, done8, hi8, lo8}); end
  endtask

  task automatic test_mult;
    logic [31:0] rh, rl; int bc; bit gd;
    do_op(3'b000, 32'hFFFFFFFD, 32'd7, rh, rl, bc, gd);
    n_chk++; if (!gd) begin n_fail++; $display("FAIL mult_done: got timeout want done"); end
    n_chk++; if (bc !== 32) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d want 32", bc); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mult_busy_at_done: got %b want 0", busy); end
    n_chk++; if ({rh, rl} !== 64'hFFFFFFFF_FFFFFFEB) begin n_fail++; $display("FAIL mult_result: got %h want FFFFFFFFFFFFFFEB", {rh, rl}); end
    @(negedge clk);
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse: got %b want 0", done); end
    do_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, rh, rl, bc, gd);
    n_chk++; if (!gd || {rh, rl} !== 64'hFFFFFFFE_00000001) begin n_fail++; $display("FAIL multu_result: got %h done=%b want FFFFFFFE00000001", {rh, rl}, gd); end
  endtask

  task automatic test_div;
    logic [31:0] rh, rl; int bc; bit gd;
    do_op(3'b011, 32'd100, 32'd7, rh, rl, bc, gd);
    n_chk++; if (!gd || rl !== 32'd14 || rh !== 32'd2) begin n_fail++; $display("FAIL divu_100_7: got lo=%h hi=%h want lo=e hi=2", rl, rh); end
    do_op(3'b010, 32'hFFFFFFF9, 32'd2, rh, rl, bc, gd);
    n_chk++; if (!gd || rl !== 32'hFFFFFFFD || rh !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_m7_2: got lo=%h hi=%h want lo=fffffffd hi=ffffffff", rl, rh); end
    do_op(3'b010, 32'd7, 32'hFFFFFFFE, rh, rl, bc, gd);
    n_chk++; if (!gd || rl !== 32'hFFFFFFFD || rh !== 32'h1) begin n_fail++; $display("FAIL div_7_m2: got lo=%h hi=%h want lo=fffffffd hi=1", rl, rh); end
    do_op(3'b010, 32'h80000000, 32'hFFFFFFFF, rh, rl, bc, gd);
    n_chk++; if (!gd || rl !== 32'h80000000 || rh !== 32'h0) begin n_fail++; $display("FAIL div_min_m1: got lo=%h hi=%h want lo=80000000 hi=0", rl, rh); end
    do_op(3'b010, 32'hFFFFFFFB, 32'h0, rh, rl, bc, gd);
    n_chk++; if (!gd || rl !== 32'hFFFFFFFF || rh !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL div_by_zero: got lo=%h hi=%h want lo=ffffffff hi=fffffffb", rl, rh); end
    n_chk++; if (bc !== 32) begin n_fail++; $display("FAIL div_by_zero_latency: got %0d want 32", bc); end
    do_op(3'b011, 32'd9, 32'h0, rh, rl, bc, gd);
    n_chk++; if (!gd || rl !== 32'hFFFFFFFF || rh !== 32'd9) begin n_fail++; $display("FAIL divu_by_zero: got lo=%h hi=%h want lo=ffffffff hi=9", rl, rh); end
  endtask

  task automatic test_ignore_while_busy;
    int dones = 0;
    @(negedge clk); start = 1; ctl = 3'b000; a = 32'd6; b = 32'd7;
    @(negedge clk); start = 0;
    for (int k = 1; k <= 45; k++) begin
      if (done) dones++;
      start = 0;
      if (k == 5)  begin start = 1; ctl = 3'b100; a = 32'hDEADBEEF; end
      if (k == 20) begin start = 1; ctl = 3'b011; a = 32'd100; b = 32'd7; end
      @(negedge clk);
    end
    start = 0;
    n_chk++; if (dones !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
    n_chk++; if (hi !== 32'h0 || lo !== 32'd42) begin n_fail++; $display("FAIL ignore_result: got hi=%h lo=%h want hi=0 lo=2a", hi, lo); end
  endtask

  task automatic test_reset_mid_op;
    int dones = 0;
    @(negedge clk); start = 1; ctl = 3'b000; a = 32'd5; b = 32'd5;
    @(negedge clk); start = 0;
    repeat (9) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    n_chk++; if ({busy, done} !== 2'b00 || hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo); end
    for (int k = 0; k < 40; k++) begin
      if (done) dones++;
      @(negedge clk);
    end
    n_chk++; if (dones !== 0) begin n_fail++; $display("FAIL reset_mid_no_done: got %0d want 0", dones); end
  endtask

  task automatic test_mtlo_mthi;
    @(negedge clk); start = 1; ctl = 3'b101; a = 32'd1234;
    @(negedge clk); start = 0;
    n_chk++; if (lo !== 32'd1234 || hi !== 32'h0) begin n_fail++; $display("FAIL mtlo: got lo=%h hi=%h want lo=4d2 hi=0", lo, hi); end
    n_chk++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL mtlo_flags: got %b want 00", {busy, done}); end
    @(negedge clk); start = 1; ctl = 3'b100; a = 32'hCAFEF00D;
    @(negedge clk); start = 0;
    n_chk++; if (hi !== 32'hCAFEF00D || lo !== 32'd1234 || {busy, done} !== 2'b00) begin n_fail++; $display("FAIL mthi: got hi=%h lo=%h flags=%b want hi=cafef00d lo=4d2 flags=00", hi, lo, {busy, done}); end
    @(negedge clk); start = 1; ctl = 3'b110; a = 32'h11111111;
    @(negedge clk); start = 0;
    n_chk++; if (hi !== 32'hCAFEF00D || lo !== 32'd1234 || busy !== 1'b0) begin n_fail++; $display("FAIL ctl110_ignored: got hi=%h lo=%h busy=%b", hi, lo, busy); end
  endtask

  task automatic test_back_to_back_w8;
    int bc = 0; bit gd = 0;
    @(negedge clk); start8 = 1; ctl8 = 3'b001; a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk); start8 = 0;
    for (int i = 0; i < 40 && !gd; i++) begin
      if (busy8) bc++;
      if (done8) gd = 1;
      else @(negedge clk);
    end
    n_chk++; if (!gd || bc !== 8) begin n_fail++; $display("FAIL w8_multu_latency: got busy=%0d done=%b want 8 and 1", bc, gd); end
    n_chk++; if (hi8 !== 8'hFE || lo8 !== 8'h01) begin n_fail++; $display("FAIL w8_multu: got hi=%h lo=%h want hi=fe lo=01", hi8, lo8); end
    // issue the next op in the done cycle
    start8 = 1; ctl8 = 3'b011; a8 = 8'd100; b8 = 8'd7;
    @(negedge clk); start8 = 0;
    n_chk++; if (busy8 !== 1'b1 || done8 !== 1'b0) begin n_fail++; $display("FAIL w8_b2b_accept: got busy=%b done=%b want 1 0", busy8, done8); end
    bc = 0; gd = 0;
    for (int i = 0; i < 40 && !gd; i++) begin
      if (busy8) bc++;
      if (done8) gd = 1;
      else @(negedge clk);
    end
    n_chk++; if (!gd || bc !== 8 || lo8 !== 8'd14 || hi8 !== 8'd2) begin n_fail++; $display("FAIL w8_b2b_divu: got busy=%0d lo=%h hi=%h want 8 lo=0e hi=02", bc, lo8, hi8); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_ignore_while_busy;
    test_reset_mid_op;
    test_mtlo_mthi;
    test_back_to_back_w8;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
